// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver (8N1 / 8E1 / 8O1 style frames).
// Bits are sampled near their centre by counting oversample ticks from the
// start-bit falling edge. Frames ending in a low stop bit are still reported,
// but the line must return high before another start bit is accepted.
module uart_rx_os #(
   parameter int OVER_SAMPLING = 8,
   parameter int DATA_BITS     = 8,
   parameter int PARITY_EN     = 0,
   parameter int PARITY_ODD    = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_enable,
   input  logic                 i_os_clk,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int CW = $clog2(OVER_SAMPLING);
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] C_HALF = CW'(OVER_SAMPLING / 2 - 1);
   localparam logic [CW-1:0] C_FULL = CW'(OVER_SAMPLING - 1);
   localparam logic [IW-1:0] C_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
   } state_t;

   state_t               r_state;
   logic                 r_os_q;
   logic                 r_rx_m;
   logic                 r_rx_s;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit;
   logic                 w_tick;
   logic                 w_par_err;

   // Rising edge of the oversample clock gives a single-cycle tick.
   assign w_tick = i_os_clk & ~r_os_q;

   // Even parity: XOR over data+parity must be 0; odd parity: must be 1.
   assign w_par_err = (PARITY_EN != 0) ?
                      ((^{r_shift, r_par_bit}) ^ (PARITY_ODD != 0)) : 1'b0;

   assign o_busy = (r_state != S_IDLE);

   // Tick edge detector and two-flop rx synchroniser (idle-high reset).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_os_q <= 1'b0;
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
      end else begin
         r_os_q <= i_os_clk;
         r_rx_m <= i_rx;
         r_rx_s <= r_rx_m;
      end
   end

   // Receive FSM: start qualification, bit sampling and result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (!i_enable) begin
            // Abort takes priority over any tick in the same cycle.
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!r_rx_s) begin
                     r_state <= S_START;
                     r_cnt   <= '0;
                  end
               end
               S_START: begin
                  if (w_tick) begin
                     if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // Start bit must still be low mid-bit, else glitch.
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_DATA: begin
                  if (w_tick) begin
                     if (r_cnt == C_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_idx == C_LAST)
                           r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else
                           r_idx <= r_idx + 1'b1;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_PARITY: begin
                  if (w_tick) begin
                     if (r_cnt == C_FULL) begin
                        r_cnt     <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_STOP: begin
                  if (w_tick) begin
                     if (r_cnt == C_FULL) begin
                        r_cnt        <= '0;
                        o_data       <= r_shift;
                        o_parity_err <= w_par_err;
                        o_frame_err  <= ~r_rx_s;
                        o_valid      <= 1'b1;
                        // A low stop bit means a break: wait for idle line.
                        r_state      <= r_rx_s ? S_IDLE : S_WAIT_IDLE;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_WAIT_IDLE: begin
                  if (r_rx_s) r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed + randomized frames into an 8N1 receiver and an
// 8E1 receiver; received bytes are compared against a frame-level model.
module tb_uart_rx_os;

   localparam int OS  = 8;
   localparam int TPT = 8;         // i_clk cycles per oversample tick
   localparam int BIT = OS * TPT;  // i_clk cycles per bit

   logic clk = 1'b0, os_clk = 1'b0, rst_n = 1'b0, en = 1'b1;
   logic rx0 = 1'b1, rx1 = 1'b1;
   logic [7:0] d0, d1;
   logic v0, pe0, fe0, b0, v1, pe1, fe1, b1;

   int total = 0, bad = 0, cyc = 0, vcyc0 = 0, t_start = 0;
   bit busy_seen0 = 1'b0;
   logic [9:0] got0[$], exp0[$], got1[$], exp1[$];

   uart_rx_os u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_os_clk(os_clk), .i_rx(rx0),
      .o_data(d0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(b0));

   uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_dutp (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_os_clk(os_clk), .i_rx(rx1),
      .o_data(d1), .o_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(b1));

   initial forever #5 clk = ~clk;
   // os_clk toggles on clk falling edges: synchronous, period = TPT clocks.
   initial forever #(5 * TPT) os_clk = ~os_clk;

   always @(posedge clk) cyc++;

   // Collect every completed-frame report as {frame_err, parity_err, data}.
   always @(negedge clk) begin
      if (v0) begin
         got0.push_back({fe0, pe0, d0});
         vcyc0 = cyc;
      end
      if (v1) got1.push_back({fe1, pe1, d1});
      if (b0) busy_seen0 = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, g, e);
      end
   endtask

   // Frame-level model: what the consumer should see for a transmitted frame.
   function automatic logic [9:0] model(input int sel, input logic [7:0] d,
                                        input logic pb, input logic sb);
      int ones;
      logic perr;
      ones = $countones(d) + int'(pb);
      perr = (sel == 1) && (ones % 2 != 0);
      return {~sb, perr, d};
   endfunction

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) rx0 = v; else rx1 = v;
   endtask

   task automatic bit_time(input int sel, input logic v);
      set_rx(sel, v);
      repeat (BIT) @(negedge clk);
   endtask

   task automatic idle(input int nbits);
      repeat (nbits * BIT) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d,
                             input logic pb, input logic sb);
      t_start = cyc;
      bit_time(sel, 1'b0);
      for (int i = 0; i < 8; i++) bit_time(sel, d[i]);
      if (sel == 1) bit_time(sel, pb);
      bit_time(sel, sb);
      if (sel == 0) exp0.push_back(model(sel, d, pb, sb));
      else          exp1.push_back(model(sel, d, pb, sb));
   endtask

   task automatic check_q(input int sel, input string tag);
      int n;
      logic [9:0] g, e;
      if (sel == 0) begin
         chk({tag, "_count"}, got0.size(), exp0.size());
         n = (got0.size() < exp0.size()) ? got0.size() : exp0.size();
         for (int i = 0; i < n; i++) begin
            g = got0[i]; e = exp0[i];
            chk({tag, "_frame"}, g, e);
         end
         got0.delete(); exp0.delete();
      end else begin
         chk({tag, "_count"}, got1.size(), exp1.size());
         n = (got1.size() < exp1.size()) ? got1.size() : exp1.size();
         for (int i = 0; i < n; i++) begin
            g = got1[i]; e = exp1[i];
            chk({tag, "_frame"}, g, e);
         end
         got1.delete(); exp1.delete();
      end
   endtask

   // 0xFF frame interrupted in the middle of data bit 3 by reset or disable.
   task automatic abort_frame(input bit use_rst, input logic [7:0] prev);
      bit_time(0, 1'b0);
      for (int i = 0; i < 3; i++) bit_time(0, 1'b1);
      set_rx(0, 1'b1);
      repeat (BIT / 2) @(negedge clk);
      chk("abort_busy_pre", b0, 1'b1);
      if (use_rst) rst_n = 1'b0; else en = 1'b0;
      @(negedge clk);
      chk("abort_busy", b0, 1'b0);
      chk("abort_data", d0, use_rst ? 8'h00 : prev);
      chk("abort_valid", v0, 1'b0);
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (BIT / 2 - 1) @(negedge clk);
      for (int i = 4; i < 9; i++) bit_time(0, 1'b1);
   endtask

   initial begin
      int lat;
      logic [7:0] rd;
      logic rb;

      // Reset state and a quiet idle line.
      repeat (3) @(negedge clk);
      chk("rst_data", d0, 8'h00);
      chk("rst_valid", v0, 1'b0);
      chk("rst_perr", pe0, 1'b0);
      chk("rst_ferr", fe0, 1'b0);
      chk("rst_busy", b0, 1'b0);
      chk("rst_busy_p", b1, 1'b0);
      rst_n = 1'b1;
      idle(20);
      check_q(0, "idle");

      // Clean 8N1 frame plus start-to-valid latency.
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      idle(2);
      lat = vcyc0 - t_start;
      check_q(0, "a5");
      chk("latency_lo", lat >= 600, 1'b1);
      chk("latency_hi", lat <= 620, 1'b1);

      // Two-tick glitch on the line is rejected.
      busy_seen0 = 1'b0;
      rx0 = 1'b0;
      repeat (2 * TPT) @(negedge clk);
      rx0 = 1'b1;
      idle(3);
      chk("glitch_busy_seen", busy_seen0, 1'b1);
      chk("glitch_busy_end", b0, 1'b0);
      check_q(0, "glitch");

      // Low stop bit then a held-low line: one report, then normal frame.
      send_frame(0, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) bit_time(0, 1'b0);
      bit_time(0, 1'b1);
      check_q(0, "brk");
      send_frame(0, 8'h11, 1'b0, 1'b1);
      idle(1);
      check_q(0, "after_brk");

      // Even parity receiver.
      send_frame(1, 8'h01, 1'b1, 1'b1);
      send_frame(1, 8'h01, 1'b0, 1'b1);
      idle(1);
      check_q(1, "par");

      // Aborted frames and recovery.
      abort_frame(1'b0, 8'h11);
      idle(1);
      check_q(0, "abort_en");
      send_frame(0, 8'h55, 1'b0, 1'b1);
      idle(1);
      check_q(0, "post_en");
      abort_frame(1'b1, 8'h55);
      idle(1);
      check_q(0, "abort_rst");
      send_frame(0, 8'h55, 1'b0, 1'b1);
      idle(1);
      check_q(0, "post_rst");

      // Back-to-back frames with a single stop bit.
      send_frame(0, 8'h00, 1'b0, 1'b1);
      send_frame(0, 8'hFF, 1'b0, 1'b1);
      idle(1);
      check_q(0, "b2b");

      // Randomized 8N1 traffic including occasional breaks.
      repeat (16) begin
         rd = 8'($urandom);
         rb = ($urandom_range(0, 3) != 0);
         send_frame(0, rd, 1'b0, rb);
         if (!rb) begin
            repeat ($urandom_range(0, 3)) bit_time(0, 1'b0);
            bit_time(0, 1'b1);
         end else begin
            repeat ($urandom_range(0, 2)) bit_time(0, 1'b1);
         end
      end
      idle(1);
      check_q(0, "rand");

      // Randomized parity traffic.
      repeat (10) begin
         rd = 8'($urandom);
         rb = 1'($urandom_range(0, 1));
         send_frame(1, rd, rb, 1'b1);
      end
      idle(1);
      check_q(1, "rand_par");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
